// File: rtl/fifo_flags.sv
// fifo_flags: synchronous single-clock FIFO with occupancy flags and sticky
// overflow/underflow error reporting.
//
// Parameters:
//   B        data word width
//   W        address width, depth = 2**W words
//   AF_LEVEL occupancy at or above which almost_full asserts (1..2**W)
//   AE_LEVEL occupancy at or below which almost_empty asserts (0..2**W-1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   wr, w_data   write request and data
//   rd           read request (pops head word)
//   flush        synchronous clear of contents
//   clr_err      synchronous clear of sticky error flags
//   r_data       head word, show-ahead
//   empty, full, almost_empty, almost_full, count   occupancy status
//   overflow, underflow                             sticky error flags
module fifo_flags #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = 2**W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    input  logic         flush,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W-1:0] PTR_ONE  = W'(1);
    localparam logic [W:0]   CNT_ONE  = (W+1)'(1);
    localparam logic [W:0]   CNT_FULL = (W+1)'(2**W);
    localparam logic [W:0]   CNT_AF   = (W+1)'(AF_LEVEL);
    localparam logic [W:0]   CNT_AE   = (W+1)'(AE_LEVEL);

    logic [B-1:0] mem [0:(2**W)-1];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic         rd_ok;
    logic         wr_ok;
    logic         ovf_set;
    logic         unf_set;

    // Flags decode straight from the registered count, so they follow the
    // asynchronous reset of count without extra flops.
    always_comb begin
        empty        = (count == '0);
        full         = (count == CNT_FULL);
        almost_empty = (count <= CNT_AE);
        almost_full  = (count >= CNT_AF);
        r_data       = mem[r_ptr];
    end

    // A write into a full FIFO is still accepted when a read pops the head
    // in the same cycle; a read on an empty FIFO is never accepted.
    always_comb begin
        rd_ok   = rd && !empty;
        wr_ok   = wr && (!full || rd_ok);
        ovf_set = !flush && wr && full && !rd;
        unf_set = !flush && rd && empty;
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // A set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow && !clr_err);
            underflow <= unf_set || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_flags.sv
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr, rd, flush, clr_err;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, almost_empty, almost_full;
    logic [2:0] count;
    logic       overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_flags #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_data(w_data),
        .flush(flush), .clr_err(clr_err), .r_data(r_data), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr, rd, fl, clr, wd;
        int cnt, emp, ful, ae, af, ovf, unf, chk, rdat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int emp, input int ful,
                           input int ae, input int af, input int ovf, input int unf);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " empty"}, 32'(empty), 32'(emp));
        chk({tag, " full"}, 32'(full), 32'(ful));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(unf));
    endtask

    task automatic drive(input int w, input int r, input int f, input int c, input int d);
        wr      = w[0];
        rd      = r[0];
        flush   = f[0];
        clr_err = c[0];
        w_data  = 8'(d);
    endtask

    initial begin
        //             wr rd fl clr wd     cnt emp ful ae af ovf unf chk rdat
        vq.push_back('{1, 0, 0, 0, 'h11,  1, 0, 0, 1, 0, 0, 0, 1, 'h11});
        vq.push_back('{1, 0, 0, 0, 'h22,  2, 0, 0, 0, 0, 0, 0, 1, 'h11});
        vq.push_back('{1, 0, 0, 0, 'h33,  3, 0, 0, 0, 1, 0, 0, 1, 'h11});
        vq.push_back('{1, 0, 0, 0, 'h44,  4, 0, 1, 0, 1, 0, 0, 1, 'h11});
        vq.push_back('{1, 0, 0, 0, 'h55,  4, 0, 1, 0, 1, 1, 0, 1, 'h11});
        vq.push_back('{0, 1, 0, 0, 'h00,  3, 0, 0, 0, 1, 1, 0, 1, 'h22});
        vq.push_back('{0, 1, 0, 0, 'h00,  2, 0, 0, 0, 0, 1, 0, 1, 'h33});
        vq.push_back('{0, 1, 0, 0, 'h00,  1, 0, 0, 1, 0, 1, 0, 1, 'h44});
        vq.push_back('{0, 1, 0, 0, 'h00,  0, 1, 0, 1, 0, 1, 0, 0, 'h00});
        vq.push_back('{0, 0, 0, 1, 'h00,  0, 1, 0, 1, 0, 0, 0, 0, 'h00});
        vq.push_back('{1, 1, 0, 0, 'hA5,  1, 0, 0, 1, 0, 0, 1, 1, 'hA5});
        vq.push_back('{0, 0, 0, 1, 'h00,  1, 0, 0, 1, 0, 0, 0, 1, 'hA5});
        vq.push_back('{1, 0, 0, 0, 'h01,  2, 0, 0, 0, 0, 0, 0, 1, 'hA5});
        vq.push_back('{1, 0, 0, 0, 'h02,  3, 0, 0, 0, 1, 0, 0, 1, 'hA5});
        vq.push_back('{1, 0, 0, 0, 'h03,  4, 0, 1, 0, 1, 0, 0, 1, 'hA5});
        vq.push_back('{1, 1, 0, 0, 'h10,  4, 0, 1, 0, 1, 0, 0, 1, 'h01});
        vq.push_back('{1, 1, 0, 0, 'h11,  4, 0, 1, 0, 1, 0, 0, 1, 'h02});
        vq.push_back('{1, 1, 0, 0, 'h12,  4, 0, 1, 0, 1, 0, 0, 1, 'h03});
        vq.push_back('{1, 1, 0, 0, 'h13,  4, 0, 1, 0, 1, 0, 0, 1, 'h10});
        vq.push_back('{1, 1, 0, 0, 'h14,  4, 0, 1, 0, 1, 0, 0, 1, 'h11});
        vq.push_back('{1, 1, 0, 0, 'h15,  4, 0, 1, 0, 1, 0, 0, 1, 'h12});
        vq.push_back('{1, 0, 0, 0, 'h5A,  4, 0, 1, 0, 1, 1, 0, 1, 'h12});
        vq.push_back('{0, 1, 0, 0, 'h00,  3, 0, 0, 0, 1, 1, 0, 1, 'h13});
        vq.push_back('{1, 1, 1, 0, 'hEE,  0, 1, 0, 1, 0, 1, 0, 0, 'h00});
        vq.push_back('{1, 1, 0, 0, 'h77,  1, 0, 0, 1, 0, 1, 1, 1, 'h77});
        vq.push_back('{1, 0, 0, 0, 'h88,  2, 0, 0, 0, 0, 1, 1, 1, 'h77});

        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        #12;
        chk_all("reset", 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            string tag;
            @(negedge clk);
            drive(vq[i].wr, vq[i].rd, vq[i].fl, vq[i].clr, vq[i].wd);
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            chk_all(tag, vq[i].cnt, vq[i].emp, vq[i].ful, vq[i].ae, vq[i].af,
                    vq[i].ovf, vq[i].unf);
            if (vq[i].chk != 0) begin
                chk({tag, " r_data"}, 32'(r_data), 32'(vq[i].rdat));
            end
        end

        // Asynchronous reset mid-stream at count=2: flags clear before any edge.
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // First write after release is the first word read.
        @(negedge clk);
        drive(1, 0, 0, 0, 'h99);
        @(negedge clk);
        drive(1, 0, 0, 0, 'h9A);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        chk("post_reset count", 32'(count), 32'd2);
        chk("post_reset head", 32'(r_data), 32'h99);
        @(negedge clk);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        chk("post_reset pop count", 32'(count), 32'd1);
        chk("post_reset pop head", 32'(r_data), 32'h9A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
